// File: rtl/aes_encrypt_ctrl.sv
// Sequencing controller for an iterative AES-256 core: owns the round-key store,
// accepts plaintext over valid/ready, steps the core and buffers one ciphertext.
module aes_encrypt_ctrl #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_KEYS   = 15
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  key_wr_en,
  input  logic [3:0]            key_wr_addr,
  input  logic [DATA_WIDTH-1:0] key_wr_data,
  input  logic                  key_commit,
  output logic                  key_loaded,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  core_rst,
  output logic                  core_en,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [DATA_WIDTH-1:0] core_round_key,
  output logic                  core_round_key_rdy,
  input  logic [3:0]            core_round_key_addr,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_data_out
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_OUT, CLEAR} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] key_store [NUM_KEYS];
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  key_wr_ok;
  logic                  accept;
  logic                  capture;

  assign key_wr_ok = (state == IDLE) && key_wr_en && (32'(key_wr_addr) < NUM_KEYS);
  assign in_ready  = (state == IDLE) && key_loaded && !key_wr_en && !key_commit && !out_valid;
  assign accept    = in_valid && in_ready;
  // Capture only into a free buffer; WAIT_OUT parks the core until it drains.
  assign capture   = ((state == RUN) || (state == WAIT_OUT)) && core_done && !out_valid;

  assign busy           = (state != IDLE);
  assign core_rst       = Rst || (state == CLEAR);
  assign core_data_in   = hold_q;
  assign core_round_key = (32'(core_round_key_addr) < NUM_KEYS) ? key_store[core_round_key_addr] : '0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) key_store[i] <= '0;
      key_loaded <= 1'b0;
    end else if (key_wr_ok) begin
      key_store[key_wr_addr] <= key_wr_data;
      key_loaded             <= 1'b0;
    end else if ((state == IDLE) && key_commit) begin
      key_loaded <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      hold_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) hold_q <= in_data;
      if (capture) begin
        out_data  <= core_data_out;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    core_en            = 1'b0;
    core_round_key_rdy = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        core_en   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        core_en            = 1'b1;
        core_round_key_rdy = !core_done;
        if (core_done) state_nxt = out_valid ? WAIT_OUT : CLEAR;
      end
      WAIT_OUT: begin
        core_en = 1'b1;
        if (capture) state_nxt = CLEAR;
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Bench for aes_encrypt_ctrl: behavioural iterative AES core, AES-256 reference
// model and a queue-based scoreboard checking ciphertext, latency and key gating.
module tb_aes_encrypt_ctrl;
  localparam int unsigned DW = 128;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          key_wr_en, key_commit, key_loaded, busy;
  logic [3:0]    key_wr_addr;
  logic [DW-1:0] key_wr_data;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          core_rst, core_en, core_round_key_rdy, core_done;
  logic [DW-1:0] core_data_in, core_round_key, core_data_out;
  logic [3:0]    core_round_key_addr;

  always #5 Clk = ~Clk;

  aes_encrypt_ctrl #(.DATA_WIDTH(DW), .NUM_KEYS(15)) dut (
    .Clk(Clk), .Rst(Rst),
    .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
    .key_commit(key_commit), .key_loaded(key_loaded), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_rst(core_rst), .core_en(core_en), .core_data_in(core_data_in),
    .core_round_key(core_round_key), .core_round_key_rdy(core_round_key_rdy),
    .core_round_key_addr(core_round_key_addr), .core_done(core_done),
    .core_data_out(core_data_out)
  );

  typedef struct {
    logic [127:0] ct;
    int unsigned  hs;
  } exp_t;

  logic [7:0]   sbox [256];
  logic [127:0] cur_rk [15];
  logic [127:0] mdl_keys [15];
  exp_t         sb [$];
  logic [3:0]   seq [$];
  logic         rdy_done;
  logic [127:0] last_ct;
  logic         prev_ov;
  int unsigned  cyc;
  int unsigned  n_cmp, n_bad;
  logic         ready_drv, bp_mode, bp_rand;

  assign out_ready = bp_mode ? bp_rand : ready_drv;

  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) bp_rand <= 1'($urandom_range(0, 1));

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input int unsigned r);
    logic [127:0] t;
    if (r == 0) return s ^ k;
    t = sub_shift(s);
    if (r < 14) t = mix(t);
    return t ^ k;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int unsigned i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int unsigned i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int unsigned r = 0; r < 15; r++) cur_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Reference: full encryption with whatever key set the controller should hold.
  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int unsigned r = 0; r < 15; r++) s = aes_round(s, mdl_keys[r], r);
    return s;
  endfunction

  // ---------------- behavioural core ----------------
  logic [127:0] core_st;
  logic [3:0]   core_cnt;
  assign core_done           = (core_cnt == 4'd15);
  assign core_round_key_addr = core_cnt;
  assign core_data_out       = core_st;

  always @(posedge Clk) begin
    if (core_rst) begin
      core_st  <= '0;
      core_cnt <= '0;
    end else if (core_en) begin
      if (core_round_key_rdy) begin
        core_st  <= aes_round(core_st, core_round_key, 32'(core_cnt));
        core_cnt <= core_cnt + 4'd1;
      end else if (core_cnt == 4'd0) begin
        core_st <= core_data_in;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s, want %s", name, got, want);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    logic ok;
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        fail("unexpected_out", "out_valid rise", "no output");
      end else begin
        e       = sb.pop_front();
        last_ct = e.ct;
        chk("ciphertext", out_data, e.ct);
        chk("latency", 128'(cyc - e.hs), 128'd18);
        ok = (seq.size() == 15) && !rdy_done && (core_round_key_addr == 4'd15);
        if (ok) foreach (seq[i]) if (seq[i] != 4'(i)) ok = 1'b0;
        chk("addr_sequence", 128'(ok), 128'd1);
      end
    end
    if (out_valid && out_ready) chk("out_data_hold", out_data, last_ct);
    if (core_rst) begin
      seq.delete();
      rdy_done = 1'b0;
    end else if (core_round_key_rdy) begin
      if (core_done) rdy_done = 1'b1;
      seq.push_back(core_round_key_addr);
    end
    prev_ov = out_valid;
  end

  // ---------------- stimulus tasks (enter and leave at posedge+1) ----------------
  task automatic do_reset();
    Rst = 1'b1;
    sb.delete();
    for (int unsigned i = 0; i < 15; i++) mdl_keys[i] = '0;
    @(posedge Clk);
    @(negedge Clk);
    chk("rst_core_rst", 128'(core_rst), 128'd1);
    chk("rst_key_loaded", 128'(key_loaded), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_core_en", 128'(core_en), 128'd0);
    chk("rst_rdy", 128'(core_round_key_rdy), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  task automatic load_keys();
    for (int unsigned i = 0; i < 15; i++) begin
      key_wr_en   = 1'b1;
      key_wr_addr = 4'(i);
      key_wr_data = cur_rk[i];
      @(posedge Clk); #1;
    end
    key_wr_en  = 1'b0;
    key_commit = 1'b1;
    @(posedge Clk); #1;
    key_commit = 1'b0;
    for (int unsigned i = 0; i < 15; i++) mdl_keys[i] = cur_rk[i];
    @(negedge Clk);
    chk("key_loaded_after_commit", 128'(key_loaded), 128'd1);
    @(posedge Clk); #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] exp_ct, output int unsigned hs);
    exp_t e;
    bit   got;
    got      = 1'b0;
    hs       = 0;
    in_valid = 1'b1;
    in_data  = pt;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (in_ready) begin
        hs   = cyc;
        e.ct = exp_ct;
        e.hs = cyc;
        sb.push_back(e);
        got  = 1'b1;
        break;
      end
    end
    @(posedge Clk); #1;
    in_valid = 1'b0;
    if (!got) fail("handshake_timeout", "no in_ready", "in_ready within 300 cycles");
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("drain_timeout", "outputs pending", "all outputs within 300 cycles");
    @(posedge Clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]   inv, b;
    int unsigned  hs0, hs1, rel;
    logic [127:0] pt, ct1;
    logic         saw;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B    = 128'hffeeddccbbaa99887766554433221100;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    n_cmp = 0; n_bad = 0; cyc = 0; prev_ov = 1'b0; rdy_done = 1'b0; last_ct = '0;
    Rst = 1'b1; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0; key_commit = 1'b0;
    in_valid = 1'b0; in_data = '0; ready_drv = 1'b1; bp_mode = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    do_reset();

    // no key set yet: block must be refused
    in_valid = 1'b1;
    in_data  = rnd128();
    @(negedge Clk);
    chk("in_ready_before_commit", 128'(in_ready), 128'd0);
    @(posedge Clk); #1;
    in_valid = 1'b0;

    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    load_keys();

    // write and commit together: write lands, key set invalid
    key_wr_en = 1'b1; key_wr_addr = 4'd3; key_wr_data = cur_rk[3]; key_commit = 1'b1;
    @(posedge Clk); #1;
    key_wr_en = 1'b0; key_commit = 1'b0;
    @(negedge Clk);
    chk("wr_commit_same_cycle", 128'(key_loaded), 128'd0);
    @(posedge Clk); #1;
    key_commit = 1'b1;
    @(posedge Clk); #1;
    key_commit = 1'b0;

    send(FIPS_PT, FIPS_CT, hs0);
    wait_drain();

    // back-to-back blocks
    send(FIPS_PT, FIPS_CT, hs0);
    send(PT_B, ref_enc(PT_B), hs1);
    chk("b2b_interval_ge19", 128'(hs1 - hs0 >= 19), 128'd1);
    wait_drain();

    // key write + commit while running are ignored
    pt = rnd128();
    send(pt, ref_enc(pt), hs0);
    repeat (5) @(posedge Clk);
    #1;
    key_wr_en = 1'b1; key_wr_addr = 4'd2; key_wr_data = rnd128(); key_commit = 1'b1;
    @(posedge Clk); #1;
    key_wr_en = 1'b0; key_commit = 1'b0;
    wait_drain();
    @(negedge Clk);
    chk("key_loaded_after_run_write", 128'(key_loaded), 128'd1);
    @(posedge Clk); #1;

    // backpressure
    ready_drv = 1'b0;
    pt  = rnd128();
    ct1 = ref_enc(pt);
    send(pt, ct1, hs0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (out_valid) begin
        saw = 1'b1;
        break;
      end
    end
    if (!saw) fail("bp_out_valid_timeout", "no out_valid", "out_valid within 40 cycles");
    @(posedge Clk); #1;
    pt       = rnd128();
    in_valid = 1'b1;
    in_data  = pt;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      chk("bp_in_ready_low", 128'(in_ready), 128'd0);
      chk("bp_out_valid_high", 128'(out_valid), 128'd1);
      chk("bp_out_data_stable", out_data, ct1);
    end
    @(posedge Clk); #1;
    ready_drv = 1'b1;
    rel = cyc;
    send(pt, ref_enc(pt), hs1);
    chk("bp_next_accept", 128'(hs1 - rel), 128'd1);
    wait_drain();

    // reset in the middle of a block
    pt = rnd128();
    send(pt, ref_enc(pt), hs0);
    repeat (7) @(posedge Clk);
    #1;
    do_reset();
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (out_valid) saw = 1'b1;
    end
    chk("no_out_after_mid_reset", 128'(saw), 128'd0);
    @(posedge Clk); #1;
    expand({rnd128(), rnd128()});
    load_keys();
    pt = rnd128();
    send(pt, ref_enc(pt), hs0);
    wait_drain();

    // random keys, blocks and output backpressure
    bp_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expand({rnd128(), rnd128()});
      load_keys();
      for (int j = 0; j < 4; j++) begin
        pt = rnd128();
        send(pt, ref_enc(pt), hs0);
      end
      wait_drain();
    end
    bp_mode = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    wait_drain();
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
